// File: rtl/regfile_scoreboard.sv
// Parametrised register bank with per-register flag and pending (scoreboard) bits.
// Optional REGFILE_ZERO_REG_EN makes register 0 a hardwired zero that is never pending.
module regfile_scoreboard #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 8,
  parameter int SEL_W    = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [SEL_W-1:0]  rd_a_sel,
  output logic [DATA_W-1:0] rd_a_data,
  output logic              rd_a_flag,
  output logic              rd_a_busy,
  input  logic [SEL_W-1:0]  rd_b_sel,
  output logic [DATA_W-1:0] rd_b_data,
  output logic              rd_b_flag,
  output logic              rd_b_busy,
  input  logic              wr_en,
  input  logic              wr_flag_en,
  input  logic [SEL_W-1:0]  wr_sel,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_flag,
  input  logic              claim_en,
  input  logic [SEL_W-1:0]  claim_sel,
  output logic              claim_ok,
  output logic              any_busy
);

`ifdef REGFILE_ZERO_REG_EN
  localparam bit ZERO_REG = 1'b1;
`else
  localparam bit ZERO_REG = 1'b0;
`endif

  logic [DATA_W-1:0]   data_reg  [NUM_REGS];
  logic [DATA_W-1:0]   data_next [NUM_REGS];
  logic [NUM_REGS-1:0] flag_reg, flag_next;
  logic [NUM_REGS-1:0] pend_reg, pend_next;
  logic [NUM_REGS-1:0] wr_hit, flag_hit, pend_eff, claim_hit;

  generate
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      // A hardwired register 0 never matches, so it keeps its reset value forever.
      localparam bit IS_ZERO = ZERO_REG && (gi == 0);

      assign wr_hit[gi]    = wr_en      && (wr_sel == SEL_W'(gi))    && !IS_ZERO;
      assign flag_hit[gi]  = wr_flag_en && (wr_sel == SEL_W'(gi))    && !IS_ZERO;
      assign claim_hit[gi] = claim_ok   && (claim_sel == SEL_W'(gi)) && !IS_ZERO;

      // Any write retires the outstanding reservation before a claim is judged.
      assign pend_eff[gi]  = pend_reg[gi] && !(wr_hit[gi] || flag_hit[gi]);

      assign data_next[gi] = wr_hit[gi]   ? wr_data : data_reg[gi];
      assign flag_next[gi] = flag_hit[gi] ? wr_flag : flag_reg[gi];
      assign pend_next[gi] = pend_eff[gi] || claim_hit[gi];
    end
  endgenerate

  assign claim_ok = claim_en && !reset && !pend_eff[claim_sel];
  assign any_busy = !reset && (|pend_reg);

  // Read ports see the post-write value, giving write-first bypass for free.
  assign rd_a_data = reset ? '0   : data_next[rd_a_sel];
  assign rd_a_flag = reset ? 1'b0 : flag_next[rd_a_sel];
  assign rd_a_busy = reset ? 1'b0 : pend_eff[rd_a_sel];
  assign rd_b_data = reset ? '0   : data_next[rd_b_sel];
  assign rd_b_flag = reset ? 1'b0 : flag_next[rd_b_sel];
  assign rd_b_busy = reset ? 1'b0 : pend_eff[rd_b_sel];

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        data_reg[i] <= '0;
      end
      flag_reg <= '0;
      pend_reg <= '0;
    end else begin
      data_reg <= data_next;
      flag_reg <= flag_next;
      pend_reg <= pend_next;
    end
  end

endmodule
